// File: rtl/piso.sv
// Parallel-in serial-out shifter with a one-entry hold register in front.
// The hold register lets the next word wait while the current word shifts, so words leave with no idle gap.
module piso #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pi_valid,
    input  logic [WIDTH-1:0] pi_data,
    output logic             pi_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             unload;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        unload      = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    unload  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    if (hold_full_q) unload  = 1'b1;
                    else             state_d = IDLE;
                end else begin
                    shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (unload) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
        end

        // A new word may land in the hold register on the same edge it unloads.
        if (pi_valid && !hold_full_q) begin
            hold_d      = pi_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pi_ready = !hold_full_q;
    assign so_valid = (state_q == SHIFT);
    assign so       = so_valid & (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
    assign so_last  = so_valid & (cnt_q == CNT_LAST);
    assign busy     = so_valid | hold_full_q;

endmodule

// File: tb/tb_piso.sv
// Scoreboard bench for piso: the driver queues expected serial bits at each accepted word and a
// negedge monitor pops and checks them; a second LSB-first instance feeds a small sipo model.
module tb_piso;

    logic       clk = 1'b0;
    logic       rst;
    logic       pi_valid, pi_ready, so, so_valid, so_last, busy;
    logic [3:0] pi_data;
    logic       l_valid, l_ready, l_so, l_so_valid, l_so_last, l_busy;
    logic [3:0] l_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic b;
        logic last;
    } exp_t;
    exp_t exp_q[$];
    logic mid = 1'b0;

    logic [3:0] po = 4'b0;
    int         l_bits = 0;
    int         l_lasts = 0;

    always #5 clk = ~clk;

    piso #(.WIDTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .pi_valid(pi_valid), .pi_data(pi_data), .pi_ready(pi_ready),
        .so(so), .so_valid(so_valid), .so_last(so_last), .busy(busy)
    );

    piso #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .pi_valid(l_valid), .pi_data(l_data), .pi_ready(l_ready),
        .so(l_so), .so_valid(l_so_valid), .so_last(l_so_last), .busy(l_busy)
    );

    // Downstream sipo receiving LSB-first: shift in at the top.
    always @(posedge clk) begin
        if (l_so_valid) begin
            po      <= {l_so, po[3:1]};
            l_bits  <= l_bits + 1;
            l_lasts <= l_lasts + (l_so_last ? 1 : 0);
        end
    end

    // Monitor: pops one expected bit per valid cycle; checks the idle line and gapless words otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mid = 1'b0;
        end else if (so_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_bit so=%0b so_last=%0b with empty scoreboard", so, so_last);
            end else begin
                e = exp_q.pop_front();
                if (so !== e.b || so_last !== e.last) begin
                    errors++;
                    $display("FAIL bit got so=%0b last=%0b want so=%0b last=%0b", so, so_last, e.b, e.last);
                end
                mid = !e.last;
            end
        end else begin
            checks++;
            if (so !== 1'b0 || so_last !== 1'b0 || mid) begin
                errors++;
                $display("FAIL idle_line got so=%0b so_last=%0b gap_in_word=%0b want 0 0 0", so, so_last, mid);
            end
            mid = 1'b0;
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offer a word on the MSB-first instance until accepted; returns just after the accepting edge.
    task automatic send(input logic [3:0] w);
        bit done = 0;
        pi_valid = 1'b1;
        pi_data  = w;
        for (int t = 0; t < 40 && !done; t++) begin
            if (pi_ready) begin
                @(posedge clk);
                for (int i = 3; i >= 0; i--) exp_q.push_back('{b: w[i], last: (i == 0)});
                done = 1;
            end else begin
                step();
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout word %h never accepted", w);
        end
        step();
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) step();
        check("drain_empty", 4'(exp_q.size()), 4'd0);
    endtask

    initial begin
        rst = 1'b1; pi_valid = 1'b0; pi_data = 4'h0; l_valid = 1'b0; l_data = 4'h0;
        step(); step();
        check("rst_so",       {3'b0, so},       4'd0);
        check("rst_so_valid", {3'b0, so_valid}, 4'd0);
        check("rst_so_last",  {3'b0, so_last},  4'd0);
        check("rst_busy",     {3'b0, busy},     4'd0);
        check("rst_pi_ready", {3'b0, pi_ready}, 4'd1);
        rst = 1'b0;
        step();

        // Single word 1011: nothing on so the cycle after acceptance, first bit one cycle later.
        send(4'b1011);
        pi_valid = 1'b0;
        check("lat_idle_valid", {3'b0, so_valid}, 4'd0);
        check("lat_busy",       {3'b0, busy},     4'd1);
        step();
        check("lat_first_valid", {3'b0, so_valid}, 4'd1);
        drain();
        step();
        check("single_done_valid", {3'b0, so_valid}, 4'd0);
        check("single_done_busy",  {3'b0, busy},     4'd0);

        // Back-to-back A then 5: gapless 8 bits, enforced by the monitor.
        send(4'hA);
        send(4'h5);
        pi_valid = 1'b0;
        drain();
        step();

        // Backpressure: A shifting, 5 held, 3 waits.
        send(4'hA);
        send(4'h5);
        check("bp_ready_low", {3'b0, pi_ready}, 4'd0);
        send(4'h3);
        pi_valid = 1'b0;
        drain();
        step();
        check("bp_idle_ready", {3'b0, pi_ready}, 4'd1);

        // Reset mid-word: F shifting two bits in, 9 held.
        send(4'hF);
        send(4'h9);
        pi_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        step();
        check("mid_rst_so",       {3'b0, so},       4'd0);
        check("mid_rst_so_valid", {3'b0, so_valid}, 4'd0);
        check("mid_rst_busy",     {3'b0, busy},     4'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("mid_rst_no_resume", {3'b0, busy}, 4'd0);

        // LSB-first instance into the sipo model.
        check("lsb_ready", {3'b0, l_ready}, 4'd1);
        l_valid = 1'b1;
        l_data  = 4'b0001;
        @(posedge clk);
        step();
        l_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("lsb_po",    po,              4'b0001);
        check("lsb_bits",  4'(l_bits),      4'd4);
        check("lsb_lasts", 4'(l_lasts),     4'd1);
        check("lsb_idle",  {3'b0, l_busy},  4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
